// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage of the 19-bit pipeline.
package fetch_pkg;

  typedef enum logic {
    S_REQ,
    S_HOLD
  } fetch_state_t;

  localparam logic [18:0] NOP_INSTR    = 19'b0;
  localparam int unsigned OPC_HI       = 18;
  localparam int unsigned OPC_LO       = 14;
  localparam logic [2:0]  JUMP_CLASS   = 3'b111;
  localparam logic [2:0]  BRANCH_CLASS = 3'b101;

  // Upper three opcode bits select the control-transfer class.
  function automatic logic is_ctrl_xfer(input logic [18:0] instr);
    logic [OPC_HI-OPC_LO:0] opcode;
    opcode = instr[OPC_HI:OPC_LO];
    return (opcode[4:2] == JUMP_CLASS) || (opcode[4:2] == BRANCH_CLASS);
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: priority is reset, then flush to NOP, then load, then hold.
module if_id_reg
  import fetch_pkg::*;
#(
  parameter int unsigned PC_W = 12
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            load,
  input  logic [18:0]     next_instr,
  input  logic [PC_W-1:0] next_pc,
  output logic [18:0]     instr,
  output logic [PC_W-1:0] pc,
  output logic            valid
);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      instr <= NOP_INSTR;
      pc    <= '0;
      valid <= 1'b0;
    end else if (load) begin
      instr <= next_instr;
      pc    <= next_pc;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, imem req/ack handshake, stall hold buffer, redirect.
// Optional performance counters enabled by defining FETCH_PERF_CNT_EN.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int unsigned     PC_W     = 12,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int unsigned     CNT_W    = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pc_writebar,
  input  logic            IF_ID_loadbar,
  input  logic            IF_ID_flush,
  input  logic [PC_W-1:0] redirect_target,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [18:0]     imem_rdata,
  output logic [18:0]     IF_ID_instruction,
  output logic [PC_W-1:0] IF_ID_pc,
  output logic            IF_ID_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
`endif
);

  if (CNT_W == 0) begin : g_bad_cnt_w
    $error("fetch_stage: CNT_W must be nonzero");
  end

  fetch_state_t    state;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] req_addr;
  logic            drop_pending;
  logic [18:0]     hold_buf;
  logic            accept;
  logic            release_hold;
  logic            id_load;
  logic [18:0]     id_next_instr;

  assign pc_inc       = pc + PC_W'(1);
  assign accept       = imem_ack & ~drop_pending & ~IF_ID_flush & ~IF_ID_loadbar & ~pc_writebar;
  assign release_hold = ~IF_ID_flush & ~IF_ID_loadbar & ~pc_writebar;
  assign id_load      = (state == S_HOLD) ? release_hold : accept;
  assign id_next_instr = (state == S_HOLD) ? hold_buf : imem_rdata;

  assign imem_req  = (state == S_REQ) & ~reset;
  assign imem_addr = req_addr;

  // req_addr only moves on an ack or when leaving S_HOLD, so the address stays
  // stable for an in-flight request even when a redirect updates pc.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_REQ;
      pc           <= RESET_PC;
      req_addr     <= RESET_PC;
      drop_pending <= 1'b0;
      hold_buf     <= NOP_INSTR;
    end else begin
      case (state)
        S_REQ: begin
          if (imem_ack) begin
            if (drop_pending || IF_ID_flush) begin
              drop_pending <= 1'b0;
              if (IF_ID_flush) begin
                pc       <= redirect_target;
                req_addr <= redirect_target;
              end else begin
                req_addr <= pc;
              end
            end else if (accept) begin
              pc       <= pc_inc;
              req_addr <= pc_inc;
            end else begin
              hold_buf <= imem_rdata;
              state    <= S_HOLD;
            end
          end else if (IF_ID_flush) begin
            pc           <= redirect_target;
            drop_pending <= 1'b1;
          end
        end
        S_HOLD: begin
          if (IF_ID_flush) begin
            pc       <= redirect_target;
            req_addr <= redirect_target;
            state    <= S_REQ;
          end else if (release_hold) begin
            pc       <= pc_inc;
            req_addr <= pc_inc;
            state    <= S_REQ;
          end
        end
      endcase
    end
  end

  if_id_reg #(
    .PC_W(PC_W)
  ) u_if_id_reg (
    .clk       (clk),
    .reset     (reset),
    .flush     (IF_ID_flush),
    .load      (id_load),
    .next_instr(id_next_instr),
    .next_pc   (pc_inc),
    .instr     (IF_ID_instruction),
    .pc        (IF_ID_pc),
    .valid     (IF_ID_valid)
  );

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (IF_ID_loadbar && !IF_ID_flush && (stall_cycles != '1))
        stall_cycles <= stall_cycles + CNT_W'(1);
      if (IF_ID_flush && (flush_count != '1))
        flush_count <= flush_count + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a same-cycle or manually acked instruction memory.
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        pc_writebar;
  logic        IF_ID_loadbar;
  logic        IF_ID_flush;
  logic [11:0] redirect_target;
  logic        imem_req;
  logic [11:0] imem_addr;
  logic        imem_ack;
  logic [18:0] imem_rdata;
  logic [18:0] IF_ID_instruction;
  logic [11:0] IF_ID_pc;
  logic        IF_ID_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] stall_cycles;
  logic [15:0] flush_count;
`endif

  logic fast_mem;
  logic man_ack;
  int   total;
  int   bad;

  function automatic logic [18:0] mem_word(input logic [11:0] a);
    return {7'h35, a};
  endfunction

  assign imem_ack   = fast_mem ? imem_req : man_ack;
  assign imem_rdata = mem_word(imem_addr);

  fetch_stage #(
    .PC_W    (12),
    .RESET_PC(12'h000),
    .CNT_W   (16)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .pc_writebar      (pc_writebar),
    .IF_ID_loadbar    (IF_ID_loadbar),
    .IF_ID_flush      (IF_ID_flush),
    .redirect_target  (redirect_target),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_ack         (imem_ack),
    .imem_rdata       (imem_rdata),
    .IF_ID_instruction(IF_ID_instruction),
    .IF_ID_pc         (IF_ID_pc),
    .IF_ID_valid      (IF_ID_valid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .stall_cycles     (stall_cycles),
    .flush_count      (flush_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; pc_writebar = 1'b0; IF_ID_loadbar = 1'b0; IF_ID_flush = 1'b0;
    redirect_target = '0; fast_mem = 1'b1; man_ack = 1'b0;
    tick(); tick();
    total++; if (IF_ID_instruction !== 19'h0) begin bad++; $display("FAIL reset_instr got=%h want=%h", IF_ID_instruction, 19'h0); end
    total++; if (IF_ID_pc !== 12'h000) begin bad++; $display("FAIL reset_pc got=%h want=%h", IF_ID_pc, 12'h000); end
    total++; if (IF_ID_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", IF_ID_valid); end
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b want=0", imem_req); end
`ifdef FETCH_PERF_CNT_EN
    total++; if (stall_cycles !== 16'd0) begin bad++; $display("FAIL reset_stall_cnt got=%0d want=0", stall_cycles); end
`endif
    reset = 1'b0;
    #1;
    total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL first_req got=%b want=1", imem_req); end
    total++; if (imem_addr !== 12'h000) begin bad++; $display("FAIL first_addr got=%h want=000", imem_addr); end
  endtask

  task automatic test_straight_line();
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (IF_ID_instruction !== mem_word(12'(i))) begin bad++; $display("FAIL line_instr[%0d] got=%h want=%h", i, IF_ID_instruction, mem_word(12'(i))); end
      total++; if (IF_ID_pc !== 12'(i + 1)) begin bad++; $display("FAIL line_pc[%0d] got=%h want=%h", i, IF_ID_pc, 12'(i + 1)); end
      total++; if (IF_ID_valid !== 1'b1) begin bad++; $display("FAIL line_valid[%0d] got=%b want=1", i, IF_ID_valid); end
    end
  endtask

  task automatic test_stall();
    tick(); tick();
    total++; if (IF_ID_instruction !== mem_word(12'd5)) begin bad++; $display("FAIL stall_pre got=%h want=%h", IF_ID_instruction, mem_word(12'd5)); end
    IF_ID_loadbar = 1'b1; pc_writebar = 1'b1;
    tick();
    total++; if (IF_ID_instruction !== mem_word(12'd5)) begin bad++; $display("FAIL stall_hold1 got=%h want=%h", IF_ID_instruction, mem_word(12'd5)); end
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL stall_req_low got=%b want=0", imem_req); end
    tick();
    total++; if (IF_ID_instruction !== mem_word(12'd5)) begin bad++; $display("FAIL stall_hold2 got=%h want=%h", IF_ID_instruction, mem_word(12'd5)); end
    total++; if (imem_addr !== 12'd6) begin bad++; $display("FAIL stall_addr got=%h want=006", imem_addr); end
`ifdef FETCH_PERF_CNT_EN
    total++; if (stall_cycles !== 16'd2) begin bad++; $display("FAIL stall_cnt got=%0d want=2", stall_cycles); end
`endif
    IF_ID_loadbar = 1'b0; pc_writebar = 1'b0;
    tick();
    total++; if (IF_ID_instruction !== mem_word(12'd6)) begin bad++; $display("FAIL stall_release got=%h want=%h", IF_ID_instruction, mem_word(12'd6)); end
    total++; if (IF_ID_pc !== 12'd7) begin bad++; $display("FAIL stall_release_pc got=%h want=007", IF_ID_pc); end
    tick();
    total++; if (IF_ID_instruction !== mem_word(12'd7)) begin bad++; $display("FAIL stall_next got=%h want=%h", IF_ID_instruction, mem_word(12'd7)); end
  endtask

  task automatic test_jump_redirect();
    IF_ID_flush = 1'b1; redirect_target = 12'h040;
    tick();
    IF_ID_flush = 1'b0;
    total++; if (IF_ID_instruction !== 19'h0) begin bad++; $display("FAIL jump_nop got=%h want=0", IF_ID_instruction); end
    total++; if (IF_ID_valid !== 1'b0) begin bad++; $display("FAIL jump_valid got=%b want=0", IF_ID_valid); end
    total++; if (imem_addr !== 12'h040) begin bad++; $display("FAIL jump_addr got=%h want=040", imem_addr); end
    tick();
    total++; if (IF_ID_instruction !== mem_word(12'h040)) begin bad++; $display("FAIL jump_target got=%h want=%h", IF_ID_instruction, mem_word(12'h040)); end
    total++; if (IF_ID_pc !== 12'h041) begin bad++; $display("FAIL jump_target_pc got=%h want=041", IF_ID_pc); end
`ifdef FETCH_PERF_CNT_EN
    total++; if (flush_count !== 16'd1) begin bad++; $display("FAIL jump_flush_cnt got=%0d want=1", flush_count); end
`endif
  endtask

  task automatic test_slow_redirect();
    fast_mem = 1'b0; man_ack = 1'b0;
    tick();
    IF_ID_flush = 1'b1; redirect_target = 12'h080;
    tick();
    IF_ID_flush = 1'b0;
    total++; if (imem_addr !== 12'h041) begin bad++; $display("FAIL slow_addr_stable got=%h want=041", imem_addr); end
    total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL slow_req_held got=%b want=1", imem_req); end
    tick();
    man_ack = 1'b1;
    tick();
    man_ack = 1'b0;
    total++; if (IF_ID_valid !== 1'b0) begin bad++; $display("FAIL slow_discard got=%b want=0", IF_ID_valid); end
    total++; if (imem_addr !== 12'h080) begin bad++; $display("FAIL slow_target_addr got=%h want=080", imem_addr); end
    total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL slow_target_req got=%b want=1", imem_req); end
    man_ack = 1'b1;
    tick();
    man_ack = 1'b0;
    total++; if (IF_ID_instruction !== mem_word(12'h080)) begin bad++; $display("FAIL slow_target_instr got=%h want=%h", IF_ID_instruction, mem_word(12'h080)); end
`ifdef FETCH_PERF_CNT_EN
    total++; if (flush_count !== 16'd2) begin bad++; $display("FAIL slow_flush_cnt got=%0d want=2", flush_count); end
`endif
  endtask

  task automatic test_stall_collision();
    tick();
    IF_ID_loadbar = 1'b1; man_ack = 1'b1;
    tick();
    man_ack = 1'b0;
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL coll_req_low got=%b want=0", imem_req); end
    total++; if (IF_ID_instruction !== mem_word(12'h080)) begin bad++; $display("FAIL coll_hold got=%h want=%h", IF_ID_instruction, mem_word(12'h080)); end
    tick();
    IF_ID_loadbar = 1'b0;
    tick();
    total++; if (IF_ID_instruction !== mem_word(12'h081)) begin bad++; $display("FAIL coll_release got=%h want=%h", IF_ID_instruction, mem_word(12'h081)); end
    total++; if (imem_addr !== 12'h082) begin bad++; $display("FAIL coll_next_addr got=%h want=082", imem_addr); end
`ifdef FETCH_PERF_CNT_EN
    total++; if (stall_cycles !== 16'd4) begin bad++; $display("FAIL coll_stall_cnt got=%0d want=4", stall_cycles); end
`endif
    fast_mem = 1'b1;
  endtask

  task automatic test_wrap();
    IF_ID_flush = 1'b1; redirect_target = 12'hFFF;
    tick();
    IF_ID_flush = 1'b0;
    tick();
    total++; if (IF_ID_instruction !== mem_word(12'hFFF)) begin bad++; $display("FAIL wrap_instr got=%h want=%h", IF_ID_instruction, mem_word(12'hFFF)); end
    total++; if (IF_ID_pc !== 12'h000) begin bad++; $display("FAIL wrap_pc got=%h want=000", IF_ID_pc); end
    tick();
    total++; if (IF_ID_instruction !== mem_word(12'h000)) begin bad++; $display("FAIL wrap_next got=%h want=%h", IF_ID_instruction, mem_word(12'h000)); end
  endtask

  task automatic test_reset_in_hold();
    IF_ID_loadbar = 1'b1; pc_writebar = 1'b1;
    tick();
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL hold_entered got=%b want=0", imem_req); end
    reset = 1'b1;
    tick();
    total++; if (IF_ID_instruction !== 19'h0) begin bad++; $display("FAIL rst_hold_instr got=%h want=0", IF_ID_instruction); end
    total++; if (IF_ID_valid !== 1'b0) begin bad++; $display("FAIL rst_hold_valid got=%b want=0", IF_ID_valid); end
    total++; if (IF_ID_pc !== 12'h000) begin bad++; $display("FAIL rst_hold_pc got=%h want=000", IF_ID_pc); end
`ifdef FETCH_PERF_CNT_EN
    total++; if (flush_count !== 16'd0) begin bad++; $display("FAIL rst_hold_flush_cnt got=%0d want=0", flush_count); end
`endif
    reset = 1'b0; IF_ID_loadbar = 1'b0; pc_writebar = 1'b0;
    #1;
    total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL rst_hold_req got=%b want=1", imem_req); end
    total++; if (imem_addr !== 12'h000) begin bad++; $display("FAIL rst_hold_addr got=%h want=000", imem_addr); end
    tick();
    total++; if (IF_ID_instruction !== mem_word(12'h000)) begin bad++; $display("FAIL rst_hold_refetch got=%h want=%h", IF_ID_instruction, mem_word(12'h000)); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_straight_line();
    test_stall();
    test_jump_redirect();
    test_slow_redirect();
    test_stall_collision();
    test_wrap();
    test_reset_in_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
